pipeif: RTL and testbench
=========================

# pipeif

Instruction-fetch stage that produces the `pc4`/`ins` pair consumed by the IF/ID pipeline register. It holds the fetch PC and drives a ready/request instruction-memory port. A 2-entry prefetch queue decouples memory latency from ID-stage stalls (`wpcir`). Redirects from ID (branch, jr, jump) squash all wrong-path fetches; there is no delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.

- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `wpcir`  in  1  1 = IF/ID loads this cycle; 0 = ID stall.
- `pcsource`  in  2  redirect select: 00 sequential, 01 `bpc`, 10 `rpc`, 11 `jpc`.
- `bpc`, `rpc`, `jpc`  in  32 each  branch, jump-register and jump targets.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `pc4`  out  32  head-entry address+4 to IF/ID; 0 when bubble.
- `ins`  out  32  head-entry instruction to IF/ID; 0 (NOP) when bubble.
- `pc`  out  32  next sequential fetch PC (`fpc`).

## Operation
- Redirect: `redir` = (`pcsource` != 00) && `wpcir`. It sets `fpc` to the selected target, clears the queue and squashes any in-flight fetch.
- Queue: 2 entries of {addr+4, instr}, FIFO. `count` ranges 0..2.
  - Pop when `wpcir` && `count`>0 && !`redir`.
  - Push on an accepted non-squashed transfer.
  - Push and pop may occur in the same cycle.
- Outputs are combinational: `ins` = (`count`==0 || `redir`) ? 0 : head.instr. `pc4` follows the same rule with head.addr+4.
- Transfer is `imem_req` && `imem_ready` at a rising edge.
- States:
  - WAIT: `imem_req`=0.
    - `redir`: `fpc`<=target, go to FETCH.
    - Otherwise, if the next-cycle `count` < 2, go to FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`fpc`.
    - Transfer && !`redir`: push {`fpc`+4, `imem_rdata`}, `fpc`<=`fpc`+4. Go to WAIT if the next-cycle `count`==2, else stay.
    - Transfer && `redir`: discard data, `fpc`<=target, stay in FETCH.
    - No transfer && `redir`: `sq_addr`<=`fpc`, `fpc`<=target, go to SQUASH.
  - SQUASH: `imem_req`=1, `imem_addr`=`sq_addr` (old address held to honour the handshake).
    - Transfer: discard data, go to FETCH.
    - `redir` (with or without transfer): `fpc`<=new target, queue stays empty.
- FETCH is never entered with `count`==2, so a push never overflows the queue.
- `fpc`+4 wraps modulo 2^32.

## Timing
- Reset (async, immediate):
  - state WAIT, `count`=0, `fpc`=`RESET_PC`, `sq_addr`=0.
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `ins`=0, `pc4`=0, `pc`=`RESET_PC`.
- First rising edge after `resetn` deasserts: WAIT to FETCH. `imem_req` is high in the following cycle.
- Latency: for a transfer at edge N, the entry appears on `ins` after edge N (if the queue was empty). IF/ID latches it at edge N+1.
- Throughput: 1 instruction/cycle with `imem_ready`=1 and `wpcir`=1. `count` holds at 1.
- Queue full (2) with a stall: `imem_req` drops the cycle after the second push. It reasserts the cycle after the first pop.
- `redir` takes priority over push and pop in the same cycle.
- `imem_req`/`imem_addr` are registered-state decodes: no combinational path from `wpcir`/`pcsource` to them.
- Reset mid-request or mid-SQUASH: all state returns to reset values immediately; the abandoned request is not resumed.

## Test plan
- Reset then stream, `imem_ready`=1, `wpcir`=1, `RESET_PC`=0:
  - `imem_addr` steps 0, 4, 8, …
  - `ins` shows each `imem_rdata` exactly one cycle after its transfer, with `pc4`=addr+4.
  - No bubbles after the first.
- Stall: `wpcir`=0 for 5 cycles mid-stream:
  - Exactly 2 entries are queued and `imem_req` goes 0.
  - On release, entries pop in order and `imem_req` reasserts the next cycle.
  - No instruction is lost or duplicated.
- Redirect with ready: `pcsource`=01, `bpc`=0x100, `wpcir`=1, `count`=1:
  - `ins`=0 that cycle and the queue is empty.
  - The next `imem_addr`=0x100 and `pc`=0x100.
- Redirect while waiting: `imem_ready`=0 at addr 0x20, `pcsource`=11, `jpc`=0x400:
  - `imem_addr` stays 0x20 until ready.
  - That data is discarded, then `imem_addr`=0x400.
  - A second redirect (`rpc`=0x800) during SQUASH results in a next fetch at 0x800.
- Wait-states: `imem_ready` high 1 of every 3 cycles:
  - Address is held stable while waiting.
  - Bubbles (`ins`=0, `pc4`=0) appear when the queue is empty, and order is preserved.
- Reset pulse while `imem_req`=1 and `count`=2: all outputs return to reset values asynchronously, and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/pipeif_if.sv
// Instruction-memory handshake bundle between the fetch stage and the
// instruction memory. The fetch stage is the master (drives the request).
interface pipeif_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pipeif.sv
// Instruction-fetch stage: holds the fetch PC, drives a ready/request
// instruction-memory port and buffers up to two fetched {pc+4, instr}
// entries so that ID-stage stalls do not throttle memory and memory wait
// states do not stall ID more than necessary. Redirects from ID squash all
// wrong-path fetches (no delay slot).
module pipeif #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wpcir,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       bpc,
    input  logic [31:0]       rpc,
    input  logic [31:0]       jpc,
    pipeif_if.master          imem,
    output logic [31:0]       pc4,
    output logic [31:0]       ins,
    output logic [31:0]       pc
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_fpc;
    logic [31:0] r_sq_addr;
    logic [31:0] r_q_pc4 [2];
    logic [31:0] r_q_ins [2];

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_xfer;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_nxt;
    logic        w_wr_idx;
    logic [31:0] w_fpc_inc;

    // Request and address decode purely from registered state, so there is
    // no combinational path from wpcir/pcsource to the memory port. The
    // squashed address is held in SQUASH so the pending handshake completes.
    assign imem.imem_req  = (r_state != ST_WAIT);
    assign imem.imem_addr = (r_state == ST_SQUASH) ? r_sq_addr : r_fpc;

    assign w_redir   = (pcsource != 2'b00) && wpcir;
    assign w_xfer    = imem.imem_req && imem.imem_ready;
    assign w_push    = (r_state == ST_FETCH) && w_xfer && !w_redir;
    assign w_pop     = wpcir && (r_count != 2'd0) && !w_redir;
    assign w_fpc_inc = r_fpc + 32'd4;
    // Tail slot: the head itself when empty, the other slot when one entry
    // is held. A push never happens with two entries held.
    assign w_wr_idx  = r_head ^ r_count[0];

    assign pc = r_fpc;

    // Redirect target select.
    always_comb begin
        w_target = r_fpc;
        case (pcsource)
            2'b01:   w_target = bpc;
            2'b10:   w_target = rpc;
            2'b11:   w_target = jpc;
            default: w_target = r_fpc;
        endcase
    end

    // Queue occupancy after this edge; a redirect empties the queue and
    // overrides any push or pop in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (w_redir) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Head entry to IF/ID; a bubble (zeros) when empty or being squashed.
    always_comb begin
        ins = 32'd0;
        pc4 = 32'd0;
        if ((r_count != 2'd0) && !w_redir) begin
            ins = r_q_ins[r_head];
            pc4 = r_q_pc4[r_head];
        end
    end

    // Fetch control FSM: state, fetch PC, squash address and queue pointers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_WAIT;
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_fpc     <= RESET_PC;
            r_sq_addr <= 32'd0;
        end else begin
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_head <= ~r_head;
            end

            case (r_state)
                ST_WAIT: begin
                    if (w_redir) begin
                        r_fpc   <= w_target;
                        r_state <= ST_FETCH;
                    end else if (w_count_nxt < 2'd2) begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (w_redir) begin
                        r_fpc <= w_target;
                        if (!w_xfer) begin
                            // Memory has not accepted yet: keep presenting
                            // the old address until it does, then drop it.
                            r_sq_addr <= r_fpc;
                            r_state   <= ST_SQUASH;
                        end
                    end else if (w_xfer) begin
                        r_fpc <= w_fpc_inc;
                        if (w_count_nxt == 2'd2) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end

                ST_SQUASH: begin
                    if (w_redir) begin
                        r_fpc <= w_target;
                    end
                    if (w_xfer) begin
                        r_state <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    // Queue storage; contents are don't-care while not counted as valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_pc4[w_wr_idx] <= w_fpc_inc;
            r_q_ins[w_wr_idx] <= imem.imem_rdata;
        end
    end

endmodule

// File: tb/tb_pipeif.sv
// Directed bench for pipeif. The instruction memory returns
// {16'hC0DE, addr[15:0]} for every address, so expected words are constants.
module tb_pipeif;

    logic        clock;
    logic        resetn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic [31:0] pc;

    int n_checks;
    int n_fail;

    pipeif_if u_if ();

    assign u_if.imem_rdata = {16'hC0DE, u_if.imem_addr[15:0]};

    pipeif #(.RESET_PC(32'h0000_0000)) u_dut (
        .clock    (clock),
        .resetn   (resetn),
        .wpcir    (wpcir),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .imem     (u_if.master),
        .pc4      (pc4),
        .ins      (ins),
        .pc       (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  {31'd0, u_if.imem_req}, 32'd0);
        check({tag, "_addr"}, u_if.imem_addr, 32'h0);
        check({tag, "_ins"},  ins, 32'h0);
        check({tag, "_pc4"},  pc4, 32'h0);
        check({tag, "_pc"},   pc,  32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        wpcir    = 1'b1;
        pcsource = 2'b00;
        bpc      = 32'h0;
        rpc      = 32'h0;
        jpc      = 32'h0;
        u_if.imem_ready = 1'b1;

        // Reset state
        #2;
        check_reset_outputs("rst");
        @(posedge clock);
        #2 resetn = 1'b1;

        // First edge after reset: WAIT -> FETCH, empty queue gives a bubble
        tick();
        check("start_req",  {31'd0, u_if.imem_req}, 32'd1);
        check("start_addr", u_if.imem_addr, 32'h0);
        check("start_ins",  ins, 32'h0);

        // Streaming at one instruction per cycle
        tick();
        check("s0_ins",  ins, 32'hC0DE_0000);
        check("s0_pc4",  pc4, 32'h0000_0004);
        check("s0_addr", u_if.imem_addr, 32'h0000_0004);
        tick();
        check("s1_ins",  ins, 32'hC0DE_0004);
        check("s1_pc4",  pc4, 32'h0000_0008);
        check("s1_addr", u_if.imem_addr, 32'h0000_0008);
        tick();
        check("s2_ins",  ins, 32'hC0DE_0008);
        check("s2_addr", u_if.imem_addr, 32'h0000_000C);
        tick();
        check("s3_ins",  ins, 32'hC0DE_000C);
        check("s3_pc4",  pc4, 32'h0000_0010);
        check("s3_addr", u_if.imem_addr, 32'h0000_0010);

        // Stall for 5 cycles: fetch at 0x10 fills the queue, request drops
        wpcir = 1'b0;
        #1;
        check("stl_hold_ins", ins, 32'hC0DE_000C);
        tick();
        check("stl1_req", {31'd0, u_if.imem_req}, 32'd0);
        check("stl1_ins", ins, 32'hC0DE_000C);
        check("stl1_pc4", pc4, 32'h0000_0010);
        check("stl1_pc",  pc,  32'h0000_0014);
        tick();
        tick();
        tick();
        check("stl4_req", {31'd0, u_if.imem_req}, 32'd0);
        tick();
        check("stl5_req", {31'd0, u_if.imem_req}, 32'd0);
        check("stl5_ins", ins, 32'hC0DE_000C);

        // Release: entries pop in order, request returns next cycle
        wpcir = 1'b1;
        #1;
        check("rel0_ins", ins, 32'hC0DE_000C);
        check("rel0_req", {31'd0, u_if.imem_req}, 32'd0);
        tick();
        check("rel1_req",  {31'd0, u_if.imem_req}, 32'd1);
        check("rel1_addr", u_if.imem_addr, 32'h0000_0014);
        check("rel1_ins",  ins, 32'hC0DE_0010);
        check("rel1_pc4",  pc4, 32'h0000_0014);
        tick();
        check("rel2_ins",  ins, 32'hC0DE_0014);
        check("rel2_addr", u_if.imem_addr, 32'h0000_0018);

        // Branch redirect with ready and one entry queued
        pcsource = 2'b01;
        bpc      = 32'h0000_0100;
        #1;
        check("br_ins",  ins, 32'h0);
        check("br_pc4",  pc4, 32'h0);
        check("br_addr", u_if.imem_addr, 32'h0000_0018);
        tick();
        pcsource = 2'b00;
        #1;
        check("br1_ins",  ins, 32'h0);
        check("br1_addr", u_if.imem_addr, 32'h0000_0100);
        check("br1_pc",   pc,  32'h0000_0100);
        tick();
        check("br2_ins",  ins, 32'hC0DE_0100);
        check("br2_pc4",  pc4, 32'h0000_0104);
        check("br2_addr", u_if.imem_addr, 32'h0000_0104);

        // Jump to 0x20, then stall memory there
        pcsource = 2'b11;
        jpc      = 32'h0000_0020;
        tick();
        pcsource = 2'b00;
        u_if.imem_ready = 1'b0;
        #1;
        check("j20_addr", u_if.imem_addr, 32'h0000_0020);
        check("j20_ins",  ins, 32'h0);
        tick();
        check("j20w_addr", u_if.imem_addr, 32'h0000_0020);

        // Redirect while the fetch at 0x20 is still pending -> SQUASH
        pcsource = 2'b11;
        jpc      = 32'h0000_0400;
        tick();
        pcsource = 2'b00;
        #1;
        check("sq1_addr", u_if.imem_addr, 32'h0000_0020);
        check("sq1_req",  {31'd0, u_if.imem_req}, 32'd1);
        check("sq1_pc",   pc, 32'h0000_0400);
        tick();
        check("sq2_addr", u_if.imem_addr, 32'h0000_0020);

        // Second redirect during SQUASH
        pcsource = 2'b10;
        rpc      = 32'h0000_0800;
        tick();
        pcsource = 2'b00;
        #1;
        check("sq3_addr", u_if.imem_addr, 32'h0000_0020);
        check("sq3_pc",   pc, 32'h0000_0800);

        // Memory finally accepts 0x20; its data must be discarded
        u_if.imem_ready = 1'b1;
        #1;
        check("sqx_ins", ins, 32'h0);
        tick();
        check("sq4_addr", u_if.imem_addr, 32'h0000_0800);
        check("sq4_ins",  ins, 32'h0);
        tick();
        check("sq5_ins",  ins, 32'hC0DE_0800);
        check("sq5_pc4",  pc4, 32'h0000_0804);
        check("sq5_addr", u_if.imem_addr, 32'h0000_0804);

        // Wait states: ready one cycle in three
        u_if.imem_ready = 1'b0;
        tick();
        check("ws1_ins",  ins, 32'h0);
        check("ws1_pc4",  pc4, 32'h0);
        check("ws1_addr", u_if.imem_addr, 32'h0000_0804);
        tick();
        check("ws2_addr", u_if.imem_addr, 32'h0000_0804);
        check("ws2_ins",  ins, 32'h0);
        u_if.imem_ready = 1'b1;
        tick();
        u_if.imem_ready = 1'b0;
        #1;
        check("ws3_ins",  ins, 32'hC0DE_0804);
        check("ws3_pc4",  pc4, 32'h0000_0808);
        check("ws3_addr", u_if.imem_addr, 32'h0000_0808);
        tick();
        check("ws4_ins",  ins, 32'h0);
        check("ws4_addr", u_if.imem_addr, 32'h0000_0808);
        tick();
        u_if.imem_ready = 1'b1;
        tick();
        check("ws6_ins",  ins, 32'hC0DE_0808);
        check("ws6_addr", u_if.imem_addr, 32'h0000_080C);

        // Fill the queue under stall, then reset asynchronously
        wpcir = 1'b0;
        tick();
        check("full_req", {31'd0, u_if.imem_req}, 32'd0);
        check("full_ins", ins, 32'hC0DE_0808);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("rstq");
        #2 resetn = 1'b1;
        wpcir = 1'b1;
        tick();
        check("rs_req",  {31'd0, u_if.imem_req}, 32'd1);
        check("rs_addr", u_if.imem_addr, 32'h0);
        check("rs_ins",  ins, 32'h0);

        // Reset in the middle of a pending request
        u_if.imem_ready = 1'b0;
        tick();
        check("mid_req", {31'd0, u_if.imem_req}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check_reset_outputs("rstm");
        #2 resetn = 1'b1;
        u_if.imem_ready = 1'b1;
        tick();
        check("rm_addr", u_if.imem_addr, 32'h0);
        tick();
        check("rm_ins",  ins, 32'hC0DE_0000);
        check("rm_pc4",  pc4, 32'h0000_0004);
        check("rm_addr2", u_if.imem_addr, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
